// File: rtl/tqvp_heartbeat_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tqvp_heartbeat_pkg
// Purpose  : Register map, FSM encoding and write helpers for the heartbeat
//            peripheral.
// Revision : 1.0
// ============================================================================
package tqvp_heartbeat_pkg;

    localparam logic [5:0] ADDR_CTRL        = 6'h00;
    localparam logic [5:0] ADDR_PERIOD      = 6'h01;
    localparam logic [5:0] ADDR_PULSE_LEN   = 6'h02;
    localparam logic [5:0] ADDR_ACK_TIMEOUT = 6'h03;
    localparam logic [5:0] ADDR_KICK        = 6'h04;
    localparam logic [5:0] ADDR_STATUS      = 6'h05;
    localparam logic [5:0] ADDR_PAT_COUNT   = 6'h06;
    localparam logic [5:0] ADDR_UI          = 6'h07;

    localparam logic [1:0] WN_8    = 2'b00;
    localparam logic [1:0] WN_16   = 2'b01;
    localparam logic [1:0] WN_32   = 2'b10;
    localparam logic [1:0] WN_NONE = 2'b11;

    localparam int STAT_MISSED_BIT  = 0;
    localparam int STAT_EXPIRED_BIT = 1;
    localparam int STAT_STATE_LSB   = 2;
    localparam int STAT_PAT_BIT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_ACKW  = 2'd3
    } hb_state_t;

    function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  wn);
        case (wn)
            WN_8:    return {old_val[31:8], wdata[7:0]};
            WN_16:   return {old_val[31:16], wdata[15:0]};
            WN_32:   return wdata;
            default: return old_val;
        endcase
    endfunction

    function automatic logic [31:0] at_least_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tqvp_stevej_heartbeat.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tqvp_stevej_heartbeat
// Purpose  : Windowed pat generator for an external watchdog with ack check.
//            Optional macro TQVP_HEARTBEAT_PAT_COUNT_EN adds PAT_COUNT at 0x6.
// Revision : 1.0
// ============================================================================
module tqvp_stevej_heartbeat
    import tqvp_heartbeat_pkg::*;
#(
    parameter logic [31:0] PERIOD_RST      = 32'd1024,
    parameter logic [7:0]  PULSE_LEN_RST   = 8'd4,
    parameter logic [15:0] ACK_TIMEOUT_RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic        en;
    logic [31:0] period;
    logic [7:0]  pulse_len;
    logic [15:0] ack_timeout;
    hb_state_t   state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic        pat_out;
    logic        missed_ack, wd_expired, expired_prev;
    logic        set_missed;
    logic [31:0] pat_count_rd;

    logic wr, wr_ctrl, wr_status, kick, en_nx, expired_rise;

    assign wr        = (data_write_n != WN_NONE);
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign kick      = wr && (address == ADDR_KICK);
    // A CTRL write steers the FSM in the same cycle so EN=0 lands in IDLE next cycle.
    assign en_nx     = wr_ctrl ? data_in[0] : en;
    assign expired_rise = ui_in[1] & ~expired_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b0;
            period      <= PERIOD_RST;
            pulse_len   <= PULSE_LEN_RST;
            ack_timeout <= ACK_TIMEOUT_RST;
        end else begin
            if (wr_ctrl)
                en <= data_in[0];
            if (wr && address == ADDR_PERIOD)
                period <= merge_write(period, data_in, data_write_n);
            if (wr && address == ADDR_PULSE_LEN)
                pulse_len <= data_in[7:0];
            if (wr && address == ADDR_ACK_TIMEOUT)
                ack_timeout <= (data_write_n == WN_8) ? {ack_timeout[15:8], data_in[7:0]}
                                                      : data_in[15:0];
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        set_missed = 1'b0;
        if (!en_nx) begin
            state_nx = ST_IDLE;
            cnt_nx   = 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_WAIT;
                    cnt_nx   = at_least_one(period);
                end
                ST_WAIT: begin
                    if (kick || cnt <= 32'd1) begin
                        state_nx = ST_PULSE;
                        cnt_nx   = at_least_one({24'd0, pulse_len});
                    end else begin
                        cnt_nx = cnt - 32'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt <= 32'd1) begin
                        if (ack_timeout == 16'd0) begin
                            state_nx = ST_WAIT;
                            cnt_nx   = at_least_one(period);
                        end else begin
                            state_nx = ST_ACKW;
                            cnt_nx   = {16'd0, ack_timeout};
                        end
                    end else begin
                        cnt_nx = cnt - 32'd1;
                    end
                end
                ST_ACKW: begin
                    if (ui_in[0]) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = at_least_one(period);
                    end else if (cnt <= 32'd1) begin
                        set_missed = 1'b1;
                        state_nx   = ST_WAIT;
                        cnt_nx     = at_least_one(period);
                    end else begin
                        cnt_nx = cnt - 32'd1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 32'd0;
            pat_out      <= 1'b0;
            missed_ack   <= 1'b0;
            wd_expired   <= 1'b0;
            expired_prev <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            pat_out      <= (state_nx == ST_PULSE);
            expired_prev <= ui_in[1];
            // Set has priority over a simultaneous W1C.
            missed_ack   <= set_missed |
                            (missed_ack & ~(wr_status & data_in[STAT_MISSED_BIT]));
            wd_expired   <= expired_rise |
                            (wd_expired & ~(wr_status & data_in[STAT_EXPIRED_BIT]));
        end
    end

`ifdef TQVP_HEARTBEAT_PAT_COUNT_EN
    logic [15:0] pat_count;

    always_ff @(posedge clk) begin
        if (rst)
            pat_count <= 16'd0;
        else if (wr && address == ADDR_PAT_COUNT)
            pat_count <= 16'd0;
        else if (state_nx == ST_PULSE && state != ST_PULSE)
            pat_count <= pat_count + 16'd1;
    end

    assign pat_count_rd = {16'd0, pat_count};
`else
    assign pat_count_rd = 32'd0;
`endif

    always_comb begin
        data_out = 32'd0;
        case (address)
            ADDR_CTRL:        data_out = {31'd0, en};
            ADDR_PERIOD:      data_out = period;
            ADDR_PULSE_LEN:   data_out = {24'd0, pulse_len};
            ADDR_ACK_TIMEOUT: data_out = {16'd0, ack_timeout};
            ADDR_STATUS:      data_out = {27'd0, pat_out, state, wd_expired, missed_ack};
            ADDR_PAT_COUNT:   data_out = pat_count_rd;
            ADDR_UI:          data_out = {24'd0, ui_in};
            default:          data_out = 32'd0;
        endcase
    end

    assign user_interrupt = missed_ack | wd_expired;
    assign data_ready     = 1'b1;
    assign uo_out         = {2'b00, state, user_interrupt, ~pat_out, pat_out, 1'b0};

    logic unused_ok;
    assign unused_ok = &{1'b0, data_read_n};

endmodule
`default_nettype wire

// File: tb/tb_tqvp_stevej_heartbeat.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tqvp_stevej_heartbeat
// Purpose  : Directed register vectors plus pat timing sequences.
// Revision : 1.0
// ============================================================================
module tb_tqvp_stevej_heartbeat;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tqvp_stevej_heartbeat dut (
        .clk            (clk),
        .rst            (rst),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  wn;
        logic [7:0]  ui;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        step();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    // Steps until pat_out equals level; returns step count or -1 on timeout.
    task automatic wait_level(input logic level, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            n++;
            if (uo_out[1] == level) return;
        end
        n = -1;
    endtask

    logic [31:0] rdata;
    int          n;

    initial begin
        vecs[0]  = '{6'h00, 32'hFFFF_FFFE, 2'b10, 8'h00, 32'h0000_0000};
        vecs[1]  = '{6'h01, 32'h1234_5678, 2'b10, 8'h00, 32'h1234_5678};
        vecs[2]  = '{6'h01, 32'h0000_00FF, 2'b00, 8'h00, 32'h1234_56FF};
        vecs[3]  = '{6'h01, 32'hFFFF_ABCD, 2'b01, 8'h00, 32'h1234_ABCD};
        vecs[4]  = '{6'h02, 32'hFFFF_FF07, 2'b10, 8'h00, 32'h0000_0007};
        vecs[5]  = '{6'h02, 32'h0000_1209, 2'b01, 8'h00, 32'h0000_0009};
        vecs[6]  = '{6'h03, 32'hFFFF_0010, 2'b10, 8'h00, 32'h0000_0010};
        vecs[7]  = '{6'h03, 32'hFFFF_FF22, 2'b00, 8'h00, 32'h0000_0022};
        vecs[8]  = '{6'h04, 32'h0000_0001, 2'b10, 8'h00, 32'h0000_0000};
        vecs[9]  = '{6'h06, 32'h0000_1234, 2'b10, 8'h00, 32'h0000_0000};
        vecs[10] = '{6'h08, 32'hFFFF_FFFF, 2'b10, 8'h00, 32'h0000_0000};
        vecs[11] = '{6'h05, 32'h0000_00FF, 2'b00, 8'h00, 32'h0000_0000};
        vecs[12] = '{6'h07, 32'h0000_0000, 2'b11, 8'hA4, 32'h0000_00A4};
        vecs[13] = '{6'h3F, 32'hFFFF_FFFF, 2'b10, 8'h00, 32'h0000_0000};

        rst          = 1'b1;
        ui_in        = 8'h00;
        address      = 6'h00;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        repeat (3) step();

        check("reset_uo_out", {24'd0, uo_out}, 32'h04);
        check("reset_irq", {31'd0, user_interrupt}, 32'd0);
        check("data_ready", {31'd0, data_ready}, 32'd1);
        rd(6'h00, rdata); check("reset_ctrl", rdata, 32'd0);
        rd(6'h01, rdata); check("reset_period", rdata, 32'd1024);
        rd(6'h02, rdata); check("reset_pulse_len", rdata, 32'd4);
        rd(6'h03, rdata); check("reset_ack_timeout", rdata, 32'd0);
        rd(6'h05, rdata); check("reset_status", rdata, 32'd0);

        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            ui_in = vecs[i].ui;
            if (vecs[i].wn != 2'b11)
                wr(vecs[i].addr, vecs[i].wdata, vecs[i].wn);
            else
                step();
            rd(vecs[i].addr, rdata);
            check($sformatf("reg_vec%0d", i), rdata, vecs[i].exp);
        end
        ui_in = 8'h00;

        // Periodic pats: 10 cycle period, 3 cycle pulse, no ack window.
        wr(6'h02, 32'd3, 2'b10);
        wr(6'h03, 32'd0, 2'b10);
        wr(6'h01, 32'd10, 2'b10);
        wr(6'h00, 32'd1, 2'b10);
        wait_level(1'b1, n); check("first_rise_delay", n, 32'd10);
        check("state_pulse", {30'd0, uo_out[5:4]}, 32'd2);
        wait_level(1'b0, n); check("pulse_width", n, 32'd3);
        wait_level(1'b1, n); check("low_gap", n, 32'd10);
        check("no_irq_periodic", {31'd0, user_interrupt}, 32'd0);

        // KICK five cycles into a long WAIT.
        wr(6'h00, 32'd0, 2'b10);
        wr(6'h01, 32'd1000, 2'b10);
        wr(6'h00, 32'd1, 2'b10);
        repeat (4) step();
        check("state_wait_before_kick", {30'd0, uo_out[5:4]}, 32'd1);
        wr(6'h04, 32'd1, 2'b10);
        check("kick_rise", {31'd0, uo_out[1]}, 32'd1);
        wait_level(1'b0, n); check("kick_pulse_width", n, 32'd3);
        wait_level(1'b1, n); check("after_kick_gap", n, 32'd1000);

        // Ack window of 4 with no ack: missed_ack sets four cycles after pulse end.
        wr(6'h00, 32'd0, 2'b10);
        wr(6'h01, 32'd10, 2'b10);
        wr(6'h03, 32'd4, 2'b10);
        wr(6'h00, 32'd1, 2'b10);
        wait_level(1'b1, n);
        wait_level(1'b0, n);
        check("state_ackw", {30'd0, uo_out[5:4]}, 32'd3);
        repeat (3) step();
        check("irq_before_timeout", {31'd0, user_interrupt}, 32'd0);
        step();
        check("irq_on_timeout", {31'd0, user_interrupt}, 32'd1);
        rd(6'h05, rdata); check("status_missed", rdata, 32'h5);
        wr(6'h05, 32'h1, 2'b00);
        rd(6'h05, rdata); check("status_missed_cleared", rdata, 32'h4);
        check("irq_cleared", {31'd0, user_interrupt}, 32'd0);

        // Same window, ack arrives in the first ACKW cycle.
        wait_level(1'b1, n);
        wait_level(1'b0, n);
        ui_in = 8'h01;
        step();
        check("ack_to_wait", {30'd0, uo_out[5:4]}, 32'd1);
        ui_in = 8'h00;
        repeat (6) step();
        rd(6'h05, rdata); check("ack_no_missed", {31'd0, rdata[0]}, 32'd0);
        check("ack_no_irq", {31'd0, user_interrupt}, 32'd0);

        // wd_expired edge detection with EN=0, and set-wins-over-clear.
        wr(6'h00, 32'd0, 2'b10);
        ui_in = 8'h02;
        step();
        check("expired_irq", {31'd0, user_interrupt}, 32'd1);
        rd(6'h05, rdata); check("status_expired", rdata, 32'h2);
        ui_in = 8'h00;
        step();
        wr(6'h05, 32'h2, 2'b00);
        rd(6'h05, rdata); check("expired_cleared", rdata, 32'h0);
        address      = 6'h05;
        data_in      = 32'h2;
        data_write_n = 2'b00;
        ui_in        = 8'h02;
        step();
        data_write_n = 2'b11;
        rd(6'h05, rdata); check("set_wins_over_clear", rdata, 32'h2);
        wr(6'h05, 32'h2, 2'b00);
        rd(6'h05, rdata); check("level_no_reset", rdata, 32'h0);
        ui_in = 8'h00;

        // EN dropped mid-pulse.
        wr(6'h01, 32'd10, 2'b10);
        wr(6'h03, 32'd0, 2'b10);
        wr(6'h00, 32'd1, 2'b10);
        wait_level(1'b1, n);
        wr(6'h00, 32'd0, 2'b10);
        check("en_off_mid_pulse", {24'd0, uo_out}, 32'h04);

        // Reset mid-pulse restores defaults.
        wr(6'h01, 32'h55, 2'b10);
        wr(6'h00, 32'd1, 2'b10);
        wait_level(1'b1, n); check("rise_before_rst", n, 32'h55);
        rst = 1'b1;
        step();
        check("rst_mid_pulse_uo", {24'd0, uo_out}, 32'h04);
        rd(6'h01, rdata); check("rst_period", rdata, 32'd1024);
        rd(6'h00, rdata); check("rst_ctrl", rdata, 32'd0);
        rst = 1'b0;
        step();

        // Three pats then PAT_COUNT readback.
        wr(6'h01, 32'd10, 2'b10);
        wr(6'h06, 32'd0, 2'b10);
        wr(6'h00, 32'd1, 2'b10);
        for (int k = 0; k < 3; k++) begin
            wait_level(1'b1, n);
            wait_level(1'b0, n);
        end
        rd(6'h06, rdata);
`ifdef TQVP_HEARTBEAT_PAT_COUNT_EN
        check("pat_count", rdata, 32'd3);
`else
        check("pat_count_absent", rdata, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
